// File: rtl/arbiter_hold.sv
// arbiter_hold: round-robin arbiter with grant hold.
// A granted requester keeps ownership while its request bit stays high, up to
// MAX_HOLD consecutive cycles (0 = unlimited), after which the grant is
// rotated to the next requester in round-robin order.
//
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - synchronous reset, active-high
//   request  - bit i high = requester i wants or keeps ownership
//   grant    - registered one-hot (or zero) grant vector
//   grant_id - registered binary index of the granted port
//   active   - registered, high whenever any grant bit is high
//   preempt  - registered one-cycle pulse after a MAX_HOLD expiry
module arbiter_hold #(
  parameter int NUM_PORTS = 6,
  parameter int ID_WIDTH  = 3,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] request,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ID_WIDTH-1:0]  grant_id,
  output logic                 active,
  output logic                 preempt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

  logic [0:0]           state, state_nxt;
  logic [ID_WIDTH-1:0]  ptr, ptr_nxt;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_cnt_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [ID_WIDTH-1:0]  grant_id_nxt;
  logic                 preempt_nxt;

  logic                 own_req;
  logic                 expired;
  logic [ID_WIDTH-1:0]  after_owner;
  logic [ID_WIDTH:0]    pick;

  // Round-robin search starting at p. Returns {found, index}.
  // The request vector is doubled so a plain right shift performs the wrap.
  function automatic logic [ID_WIDTH:0] sel(input logic [NUM_PORTS-1:0] req,
                                            input logic [ID_WIDTH-1:0]  p);
    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] tmp;
    logic                   found;
    logic [ID_WIDTH-1:0]    idx;
    int                     pos;
    dbl   = {req, req} >> p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      tmp = dbl >> k;
      if (!found && tmp[0]) begin
        found = 1'b1;
        pos   = int'(p) + k;
        if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
        idx   = ID_WIDTH'(pos);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    preempt_nxt  = 1'b0;

    own_req     = request[grant_id];
    expired     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    after_owner = (grant_id == LAST_PORT) ? '0 : grant_id + ID_WIDTH'(1);
    pick        = '0;

    if (state == IDLE) begin
      pick = sel(request, ptr);
      if (pick[ID_WIDTH]) begin
        state_nxt    = OWN;
        grant_nxt    = NUM_PORTS'(1) << pick[ID_WIDTH-1:0];
        grant_id_nxt = pick[ID_WIDTH-1:0];
        hold_cnt_nxt = '0;
      end
    end else if (own_req && !expired) begin
      // Owner keeps the resource; with unlimited hold the counter stays idle.
      if (MAX_HOLD != 0) hold_cnt_nxt = hold_cnt + CNT_WIDTH'(1);
    end else begin
      // Grant ends (release or expiry). The old owner becomes lowest priority,
      // and on expiry it is found again only if nobody else is requesting.
      ptr_nxt      = after_owner;
      pick         = sel(request, after_owner);
      hold_cnt_nxt = '0;
      if (pick[ID_WIDTH]) begin
        grant_nxt    = NUM_PORTS'(1) << pick[ID_WIDTH-1:0];
        grant_id_nxt = pick[ID_WIDTH-1:0];
        preempt_nxt  = own_req;
      end else begin
        state_nxt    = IDLE;
        grant_nxt    = '0;
        grant_id_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      active   <= |grant_nxt;
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_arbiter_hold.sv
// tb_arbiter_hold: directed bench for arbiter_hold.
// Three instances share clk/rst: default build (MAX_HOLD=16), a MAX_HOLD=1
// build and an unlimited-hold build (MAX_HOLD=0).
module tb_arbiter_hold;

  logic       clk;
  logic       rst;
  logic [5:0] request;
  logic [5:0] request1;

  logic [5:0] grant,  grant1,  grant0;
  logic [2:0] gid,    gid1,    gid0;
  logic       active, active1, active0;
  logic       preempt, preempt1, preempt0;

  int n_vec;
  int n_err;

  arbiter_hold #(.NUM_PORTS(6), .ID_WIDTH(3), .MAX_HOLD(16), .CNT_WIDTH(5)) u_dut (
    .clk(clk), .rst(rst), .request(request),
    .grant(grant), .grant_id(gid), .active(active), .preempt(preempt));

  arbiter_hold #(.NUM_PORTS(6), .ID_WIDTH(3), .MAX_HOLD(1), .CNT_WIDTH(1)) u_hold1 (
    .clk(clk), .rst(rst), .request(request1),
    .grant(grant1), .grant_id(gid1), .active(active1), .preempt(preempt1));

  arbiter_hold #(.NUM_PORTS(6), .ID_WIDTH(3), .MAX_HOLD(0), .CNT_WIDTH(5)) u_hold0 (
    .clk(clk), .rst(rst), .request(request),
    .grant(grant0), .grant_id(gid0), .active(active0), .preempt(preempt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [5:0] req;
    logic [5:0] grant;
    logic [2:0] id;
    logic       active;
    logic       preempt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rise.
  task automatic step(input logic r, input logic [5:0] q);
    @(negedge clk);
    rst     = r;
    request = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string name, input int idx, input logic [5:0] g,
                          input logic [2:0] id, input logic a, input logic p);
    chk({name, ".grant"},   idx, 32'(grant),   32'(g));
    chk({name, ".id"},      idx, 32'(gid),     32'(id));
    chk({name, ".active"},  idx, 32'(active),  32'(a));
    chk({name, ".preempt"}, idx, 32'(preempt), 32'(p));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    request  = '0;
    request1 = '0;

    //            rst   req        grant      id    act   pre
    vecs[0]  = '{1'b1, 6'b111111, 6'b000000, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 6'b000100, 6'b000100, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 6'b000110, 6'b000100, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 6'b000010, 6'b000010, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 6'b000110, 6'b000010, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6'b000100, 6'b000100, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 6'b100001, 6'b100000, 3'd5, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 6'b000001, 6'b000001, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 6'b111111, 6'b000010, 3'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 6'b111111, 6'b000010, 3'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 6'b101000, 6'b001000, 3'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 6'b111111, 6'b000000, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 6'b111111, 6'b000001, 3'd0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 6'b000000, 6'b000000, 3'd0, 1'b0, 1'b0};

    step(1'b1, 6'b000000);
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].req);
      chk_main("vec", i, vecs[i].grant, vecs[i].id, vecs[i].active, vecs[i].preempt);
    end

    // Single requester: 16 cycles of ownership, then a preempting re-grant.
    step(1'b1, 6'b000000);
    for (int k = 1; k <= 18; k++) begin
      step(1'b0, 6'b000100);
      chk_main("solo", k, 6'b000100, 3'd2, 1'b1, (k == 17) ? 1'b1 : 1'b0);
    end

    // All requesting: rotation every 16 cycles with a preempt pulse at each
    // handoff. The unlimited-hold instance must keep port 0 throughout.
    step(1'b1, 6'b000000);
    for (int k = 1; k <= 97; k++) begin
      int owner;
      owner = ((k - 1) / 16) % 6;
      step(1'b0, 6'b111111);
      chk("rr.grant",   k, 32'(grant),   32'(6'b1 << owner));
      chk("rr.id",      k, 32'(gid),     32'(owner));
      chk("rr.active",  k, 32'(active),  32'd1);
      chk("rr.preempt", k, 32'(preempt), (k > 1 && ((k - 1) % 16) == 0) ? 32'd1 : 32'd0);
      chk("nohold.grant",   k, 32'(grant0),   32'(6'b000001));
      chk("nohold.preempt", k, 32'(preempt0), 32'd0);
    end

    // Release mid-hold: the next owner gets a full fresh hold window.
    step(1'b1, 6'b000000);
    step(1'b0, 6'b000010);
    chk_main("rel.start", 0, 6'b000010, 3'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 6'b000110);
      chk_main("rel.hold", k, 6'b000010, 3'd1, 1'b1, 1'b0);
    end
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 6'b000100);
      chk_main("rel.new", k, 6'b000100, 3'd2, 1'b1, (k == 17) ? 1'b1 : 1'b0);
    end

    // MAX_HOLD=1: alternate ports 1,3,5 every cycle, never idle.
    step(1'b1, 6'b000000);
    for (int k = 0; k < 9; k++) begin
      int owner;
      owner = 1 + 2 * (k % 3);
      @(negedge clk);
      rst      = 1'b0;
      request1 = 6'b101010;
      @(posedge clk);
      #1;
      chk("h1.grant",   k, 32'(grant1),   32'(6'b1 << owner));
      chk("h1.id",      k, 32'(gid1),     32'(owner));
      chk("h1.active",  k, 32'(active1),  32'd1);
      chk("h1.preempt", k, 32'(preempt1), (k > 0) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_hold.md
Name: arbiter_hold

Overview:
- Round-robin arbiter with grant hold for multi-cycle ownership of a shared resource, e.g. a bus or memory port.
- Once granted, a requester keeps ownership while it holds its request bit, up to MAX_HOLD cycles; the grant is then forcibly rotated.
- Provides one-hot and binary grant outputs so a downstream datapath mux can be driven directly.

Parameters:
- NUM_PORTS, 6, number of requesters (2..32).
- ID_WIDTH, 3, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_PORTS.
- MAX_HOLD, 16, maximum consecutive cycles a single grant may last; 0 = unlimited.
- CNT_WIDTH, 5, width of the hold counter; must hold MAX_HOLD-1.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- request  input  NUM_PORTS  bit i high = requester i wants or keeps ownership.
- grant  output  NUM_PORTS  registered, one-hot or zero; bit i = requester i owns resource.
- grant_id  output  ID_WIDTH  registered binary index of the granted port; valid when active.
- active  output  1  registered; high when any grant bit is high.
- preempt  output  1  registered one-cycle pulse; high in the first cycle after a grant was revoked by MAX_HOLD expiry.

Behaviour:
- Reset values: grant=0, grant_id=0, active=0, preempt=0, hold_cnt=0, state=IDLE, rr pointer=0 (port 0 searched first).
- All outputs are registered. Request at cycle t appears as grant at t+1.
- Selection function sel(p): first i with request[i]=1, searching p, p+1, ..., NUM_PORTS-1, 0, ..., p-1.
- State IDLE:
  - If request==0: stay IDLE, outputs 0.
  - Otherwise grant sel(ptr) next cycle, set hold_cnt=0, go to OWN.
- State OWN (owner o):
  - keep: request[o]=1 and not expired, where expired = (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1). Grant unchanged; hold_cnt increments.
  - release: request[o]=0. If any other request, grant sel((o+1) mod N) next cycle, with no idle gap. Otherwise grant=0 and go to IDLE.
  - expire: request[o]=1 and expired.
    - Grant sel((o+1) mod N) next cycle; preempt=1 that cycle.
    - If o is the only requester, o is re-granted with hold_cnt=0 and preempt=1.
- ptr updates to (o+1) mod N whenever a grant to o ends, so the last owner has lowest priority.
- Every handoff resets hold_cnt to 0.
- Simultaneous drop of request[o] and a new request elsewhere is treated as release; expiry is ignored when request[o]=0.
- Requests from non-owners never disturb the current grant.
- active == |grant and grant_id == index(grant) in every cycle.
- MAX_HOLD=1: every grant lasts exactly one cycle; with continuous requests this is pure round robin.
- MAX_HOLD=0: hold_cnt is unused and expiry never fires.
- rst asserted mid-grant: next cycle all outputs and state return to reset values, regardless of request.
- Request bits at indices >= NUM_PORTS do not exist. grant_id never exceeds NUM_PORTS-1.

Test Plan:
- Reset then request=6'b000100 held: cycle 1 grant=000100, grant_id=2, active=1; grant stays for 16 cycles; preempt=1 with grant re-issued to port 2.
- request=6'b111111 continuously, MAX_HOLD=16: grant sequence 0,1,2,3,4,5,0; each grant lasts 16 cycles; preempt pulses every 16 cycles; no idle cycles.
- Port 1 owns, request=000110; port 1 drops at t: grant=000100 at t+1, hold_cnt restarts, preempt=0.
- Port 5 owns with only port 0 requesting; port 5 drops: grant moves to port 0 (wrap); then port 0 drops with request=0: grant=0, active=0 next cycle.
- rst pulsed while port 3 owns and request=111111: grant=0 the next cycle; the following cycle grants port 0.
- MAX_HOLD=1 build, request=101010: grants 1,3,5,1,... one cycle each; active stays high.
